// File: rtl/udma_l2_wr_arbiter.sv
// -----------------------------------------------------------------------------
// udma_l2_wr_arbiter
//
// Purpose:
//   Shares the single uDMA L2 write-only port between N_REQ RX-side channel
//   writers. A round-robin arbiter picks one requester per cycle. The winner
//   loads a one-entry output register, which holds the transfer until the L2
//   interconnect grants it. A retire and a new load can happen in the same
//   cycle, so the port sustains one transfer per cycle while l2_gnt_i is high.
//
// Optional feature (compile-time macro UDMA_L2_ARB_PRIO_EN):
//   Adds input prio_i. When any requester with its prio_i bit set is
//   requesting, only those requesters compete. Otherwise all requesters
//   compete. Both cases use the same round-robin pointer.
//
// Ports:
//   sys_clk_i   core clock
//   sys_rst_i   asynchronous reset, active-high
//   in_req_i    per-requester write request, held until in_gnt_o
//   in_addr_i   per-requester address, packed N_REQ x AW (requester 0 in LSBs)
//   in_wdata_i  per-requester write data, packed N_REQ x DW
//   in_be_i     per-requester byte enables, packed N_REQ x DW/8
//   prio_i      per-requester priority flag (only with UDMA_L2_ARB_PRIO_EN)
//   in_gnt_o    one-hot accept strobe, combinational, asserted in the capture cycle
//   l2_req_o    L2 write request (output register valid)
//   l2_gnt_i    L2 grant; a transfer retires when l2_req_o && l2_gnt_i
//   l2_addr_o   registered address
//   l2_wdata_o  registered write data
//   l2_be_o     registered byte enables
//   l2_id_o     index of the requester that owns the output register
//   busy_o      l2_req_o | (|in_req_i)
// -----------------------------------------------------------------------------
module udma_l2_wr_arbiter #(
  parameter int N_REQ = 8,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_i,
  input  logic [N_REQ-1:0]        in_req_i,
  input  logic [N_REQ*AW-1:0]     in_addr_i,
  input  logic [N_REQ*DW-1:0]     in_wdata_i,
  input  logic [N_REQ*(DW/8)-1:0] in_be_i,
`ifdef UDMA_L2_ARB_PRIO_EN
  input  logic [N_REQ-1:0]        prio_i,
`endif
  output logic [N_REQ-1:0]        in_gnt_o,
  output logic                    l2_req_o,
  input  logic                    l2_gnt_i,
  output logic [AW-1:0]           l2_addr_o,
  output logic [DW-1:0]           l2_wdata_o,
  output logic [DW/8-1:0]         l2_be_o,
  output logic [IDW-1:0]          l2_id_o,
  output logic                    busy_o
);

  localparam int BW = DW / 8;

  // Output register and arbitration state
  logic            req_q,    req_d;
  logic [AW-1:0]   addr_q,   addr_d;
  logic [DW-1:0]   wdata_q,  wdata_d;
  logic [BW-1:0]   be_q,     be_d;
  logic [IDW-1:0]  id_q,     id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  // Unpacked views of the flattened requester buses
  logic [AW-1:0] addr_arr  [N_REQ];
  logic [DW-1:0] wdata_arr [N_REQ];
  logic [BW-1:0] be_arr    [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = in_addr_i[gi*AW +: AW];
    assign wdata_arr[gi] = in_wdata_i[gi*DW +: DW];
    assign be_arr[gi]    = in_be_i[gi*BW +: BW];
  end

  // Candidate set. With priority enabled, prioritised requesters mask out the
  // others whenever at least one of them is requesting.
  logic [N_REQ-1:0] cand;
`ifdef UDMA_L2_ARB_PRIO_EN
  logic [N_REQ-1:0] prio_req;
  assign prio_req = in_req_i & prio_i;
  assign cand     = (|prio_req) ? prio_req : in_req_i;
`else
  assign cand     = in_req_i;
`endif

  // Round-robin search starts one past the last winner and wraps around.
  // Offset N_REQ is the last winner itself, so a single requester always
  // finds itself again.
  logic           win_found;
  logic [IDW-1:0] win_idx;

  always_comb begin : p_search
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!win_found && cand[IDW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  // The slot is free when it is empty or is retiring in this cycle.
  logic slot_free;
  logic accept;
  assign slot_free = !req_q || l2_gnt_i;
  assign accept    = slot_free && win_found;

  always_comb begin
    in_gnt_o = '0;
    if (accept) begin
      in_gnt_o[win_idx] = 1'b1;
    end
  end

  // Next state of the output register. A retire without a new accept only
  // clears the valid bit; the data fields keep their last value.
  always_comb begin
    req_d    = req_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      req_d    = 1'b1;
      addr_d   = addr_arr[win_idx];
      wdata_d  = wdata_arr[win_idx];
      be_d     = be_arr[win_idx];
      id_d     = win_idx;
      rr_ptr_d = win_idx;
    end else if (req_q && l2_gnt_i) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      req_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      id_q     <= '0;
      rr_ptr_q <= IDW'(N_REQ - 1);
    end else begin
      req_q    <= req_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign l2_req_o   = req_q;
  assign l2_addr_o  = addr_q;
  assign l2_wdata_o = wdata_q;
  assign l2_be_o    = be_q;
  assign l2_id_o    = id_q;
  assign busy_o     = req_q | (|in_req_i);

endmodule

// File: tb/tb_udma_l2_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_udma_l2_wr_arbiter
//
// Self-checking bench for udma_l2_wr_arbiter (N_REQ=8, AW=32, DW=32).
// Requester i presents fixed data:
//   addr  = 0x1C000000 + i*0x100
//   wdata = 0xA5A50000 + i
//   be    = i+1
// The stimulus process drives directed cycles with a hand-written expected
// in_gnt_o value. Each expected accept pushes its requester id into a queue.
// A separate monitor pops one entry on every L2 retire and compares the
// id, addr, wdata and be of the retiring transfer.
// -----------------------------------------------------------------------------
module tb_udma_l2_wr_arbiter;

  localparam int N   = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int IDW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      in_req = '0;
  logic [N*AW-1:0]   in_addr;
  logic [N*DW-1:0]   in_wdata;
  logic [N*BW-1:0]   in_be;
  logic [N-1:0]      in_gnt;
  logic              l2_req;
  logic              l2_gnt = 1'b0;
  logic [AW-1:0]     l2_addr;
  logic [DW-1:0]     l2_wdata;
  logic [BW-1:0]     l2_be;
  logic [IDW-1:0]    l2_id;
  logic              busy;
`ifdef UDMA_L2_ARB_PRIO_EN
  logic [N-1:0]      prio = '0;
`endif

  always #5 clk = ~clk;

  udma_l2_wr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst),
    .in_req_i   (in_req),
    .in_addr_i  (in_addr),
    .in_wdata_i (in_wdata),
    .in_be_i    (in_be),
`ifdef UDMA_L2_ARB_PRIO_EN
    .prio_i     (prio),
`endif
    .in_gnt_o   (in_gnt),
    .l2_req_o   (l2_req),
    .l2_gnt_i   (l2_gnt),
    .l2_addr_o  (l2_addr),
    .l2_wdata_o (l2_wdata),
    .l2_be_o    (l2_be),
    .l2_id_o    (l2_id),
    .busy_o     (busy)
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  function automatic logic [AW-1:0] addr_of(int id);
    return 32'h1C00_0000 + 32'(id) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] wdata_of(int id);
    return 32'hA5A5_0000 + 32'(id);
  endfunction

  function automatic logic [BW-1:0] be_of(int id);
    return BW'(id + 1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One directed cycle: drive just after the rising edge, then check the
  // combinational grant on the falling edge.
  task automatic cyc(logic [N-1:0] req, logic g, logic [N-1:0] exp_g);
    @(posedge clk);
    #1;
    in_req = req;
    l2_gnt = g;
    @(negedge clk);
    check("in_gnt", 32'(in_gnt), 32'(exp_g));
    for (int i = 0; i < N; i++) begin
      if (exp_g[i]) exp_q.push_back(i);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_req = '0;
    l2_gnt = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_l2_req", 32'(l2_req), 32'd0);
    check("rst_in_gnt", 32'(in_gnt), 32'd0);
    check("rst_addr",   l2_addr,     32'd0);
    check("rst_id",     32'(l2_id),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every retire must match the oldest expected accept.
  always @(negedge clk) begin
    if (!rst && l2_req && l2_gnt) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL retire: got id %0d addr 0x%0h, expected no transfer",
                 l2_id, l2_addr);
      end else begin
        int e;
        e = exp_q.pop_front();
        tests++;
        if (l2_id !== IDW'(e) || l2_addr !== addr_of(e) ||
            l2_wdata !== wdata_of(e) || l2_be !== be_of(e)) begin
          fails++;
          $display("[TB] FAIL retire: got id %0d addr 0x%0h data 0x%0h be 0x%0h, expected id %0d addr 0x%0h data 0x%0h be 0x%0h",
                   l2_id, l2_addr, l2_wdata, l2_be, e, addr_of(e), wdata_of(e), be_of(e));
        end else begin
          $display("[TB] retire id %0d addr 0x%0h", l2_id, l2_addr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      in_addr[i*AW +: AW]  = addr_of(i);
      in_wdata[i*DW +: DW] = wdata_of(i);
      in_be[i*BW +: BW]    = be_of(i);
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("init_l2_req", 32'(l2_req), 32'd0);
    check("init_busy",   32'(busy),   32'd0);
    do_reset();

    // Single requester 3 gets every slot; l2_req_o rises one cycle later
    cyc(8'h08, 1'b1, 8'h08);
    check("lat_l2_req_c0", 32'(l2_req), 32'd0);
    cyc(8'h08, 1'b1, 8'h08);
    check("lat_l2_req_c1", 32'(l2_req), 32'd1);
    check("lat_l2_id",     32'(l2_id),  32'd3);
    cyc(8'h08, 1'b1, 8'h08);
    cyc(8'h08, 1'b1, 8'h08);
    cyc(8'h00, 1'b1, 8'h00);
    cyc(8'h00, 1'b0, 8'h00);
    check("idle_l2_req",  32'(l2_req), 32'd0);
    check("idle_keep_addr", l2_addr,   addr_of(3));
    check("idle_busy",    32'(busy),   32'd0);

    // All requesting from rr_ptr=7: 0..7 twice, one accept per cycle
    do_reset();
    for (int k = 0; k < 16; k++) begin
      logic [N-1:0] g;
      g = N'(1) << (k % N);
      cyc(8'hFF, 1'b1, g);
    end
    cyc(8'h00, 1'b1, 8'h00);

    // Backpressure with requesters 0 and 2
    cyc(8'h05, 1'b0, 8'h01);
    for (int k = 0; k < 5; k++) begin
      cyc(8'h05, 1'b0, 8'h00);
      check("stall_l2_req", 32'(l2_req), 32'd1);
      check("stall_addr",   l2_addr,     addr_of(0));
      check("stall_busy",   32'(busy),   32'd1);
    end
    cyc(8'h05, 1'b1, 8'h04);
    cyc(8'h05, 1'b1, 8'h01);
    cyc(8'h00, 1'b1, 8'h00);

    // Wrap-around: move rr_ptr to 7, then 0 wins before 7
    cyc(8'h80, 1'b1, 8'h80);
    cyc(8'h81, 1'b1, 8'h01);
    cyc(8'h81, 1'b1, 8'h80);
    cyc(8'h00, 1'b1, 8'h00);

    // Asynchronous reset drops a pending transfer (requester 1, addr 0x1C000100)
    cyc(8'h02, 1'b0, 8'h02);
    cyc(8'h00, 1'b0, 8'h00);
    check("pend_addr",   l2_addr,     32'h1C00_0100);
    check("pend_l2_req", 32'(l2_req), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_l2_req", 32'(l2_req), 32'd0);
    check("async_addr",   l2_addr,     32'd0);
    check("async_id",     32'(l2_id),  32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(8'h00, 1'b1, 8'h00);
      check("post_rst_l2_req", 32'(l2_req), 32'd0);
    end

`ifdef UDMA_L2_ARB_PRIO_EN
    // Priority subset alternates 4,5 and then round-robin resumes from 6
    do_reset();
    prio = 8'h30;
    cyc(8'hFF, 1'b1, 8'h10);
    cyc(8'hFF, 1'b1, 8'h20);
    cyc(8'hFF, 1'b1, 8'h10);
    cyc(8'hFF, 1'b1, 8'h20);
    @(posedge clk);
    #1;
    prio = 8'h00;
    @(negedge clk);
    check("prio_resume", 32'(in_gnt), 32'h40);
    exp_q.push_back(6);
    cyc(8'hFF, 1'b1, 8'h80);
    cyc(8'h00, 1'b1, 8'h00);
`endif

    cyc(8'h00, 1'b0, 8'h00);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
